fifo_write_arbiter: RTL

- Shares the single write port of one fifo_generic instance between NumReq independent producers.
- Grants one requester at a time in round-robin order and holds the grant for a burst of up to MaxBurst beats.
- Drives i_write / i_write_data of the FIFO and obeys its o_full.
- Sits directly in front of fifo_generic; the FIFO read side is untouched.

---
 rtl/fifo_write_arbiter_if.sv | 25 ++
 rtl/fifo_write_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between NumReq producers, the round-robin arbiter and one FIFO.
// master = arbiter side, slave = producers plus FIFO.
interface fifo_write_arbiter_if #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 32
) ();
  logic [NumReq-1:0]           i_req_valid;
  logic [NumReq*DataWidth-1:0] i_req_data;
  logic [NumReq-1:0]           o_req_ready;
  logic                        o_fifo_write;
  logic [DataWidth-1:0]        o_fifo_write_data;
  logic                        i_fifo_full;
  logic [NumReq-1:0]           o_grant;
  logic                        o_busy;

  modport master (
    input  i_req_valid, i_req_data, i_fifo_full,
    output o_req_ready, o_fifo_write, o_fifo_write_data, o_grant, o_busy
  );

  modport slave (
    output i_req_valid, i_req_data, i_fifo_full,
    input  o_req_ready, o_fifo_write, o_fifo_write_data, o_grant, o_busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NumReq producers.
// Beats pass straight through on the accepting edge; nothing is stored here.
module fifo_write_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 32,
  parameter int MaxBurst  = 4
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  fifo_write_arbiter_if.master bus
);
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [IdxW-1:0] LAST_IDX = IdxW'(NumReq - 1);
  localparam logic [CntW-1:0] CNT_LAST = CntW'(MaxBurst - 1);

  logic [0:0]      state_r;
  logic [IdxW-1:0] owner_r;
  logic [IdxW-1:0] rr_r;
  logic [CntW-1:0] cnt_r;

  logic [IdxW-1:0] sel_idx_s;
  logic            sel_found_s;
  logic [IdxW-1:0] rr_next_s;
  logic            in_grant_s;
  logic            owner_valid_s;
  logic            accept_s;
  logic            release_s;

  // First valid requester at or above the rr pointer, wrapping modulo NumReq
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (!sel_found_s && bus.i_req_valid[(int'(rr_r) + k) % NumReq]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = IdxW'((int'(rr_r) + k) % NumReq);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Handshake qualification; full stalls the owner but never releases it
  always_comb begin
    in_grant_s    = (state_r == ST_GRANT);
    owner_valid_s = bus.i_req_valid[owner_r];
    accept_s      = in_grant_s && owner_valid_s && !bus.i_fifo_full;
    release_s     = in_grant_s && (!owner_valid_s || (accept_s && (cnt_r == CNT_LAST)));
    rr_next_s     = (owner_r == LAST_IDX) ? '0 : (owner_r + IdxW'(1));
  end

  // Output decode straight from state so async reset clears every output at once
  always_comb begin
    bus.o_req_ready       = '0;
    bus.o_grant           = '0;
    bus.o_fifo_write      = accept_s;
    bus.o_fifo_write_data = '0;
    bus.o_busy            = in_grant_s;
    if (in_grant_s) begin
      bus.o_grant[owner_r] = 1'b1;
    end else begin
      bus.o_grant = '0;
    end
    if (accept_s) begin
      bus.o_req_ready[owner_r] = 1'b1;
      bus.o_fifo_write_data    = bus.i_req_data[int'(owner_r) * DataWidth +: DataWidth];
    end else begin
      bus.o_fifo_write_data = '0;
    end
  end

  // Arbitration state: owner, rr pointer, burst count
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      owner_r <= '0;
      rr_r    <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sel_found_s) begin
            owner_r <= sel_idx_s;
            cnt_r   <= '0;
            state_r <= ST_GRANT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (release_s) begin
            rr_r    <= rr_next_s;
            cnt_r   <= '0;
            state_r <= ST_IDLE;
          end else if (accept_s) begin
            cnt_r <= cnt_r + CntW'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end
endmodule
